// File: rtl/mem_access_ctrl.sv
// Arbitrates instruction fetch and load/store traffic onto a shared MAR/memory pair,
// strobing writes after the MAR delay and returning a one-cycle acknowledge.
module mem_access_ctrl #(
  parameter int unsigned ADDR_W  = 11,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned MEM_LAT = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] mar_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int unsigned CNT_W = $clog2(MEM_LAT + 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;
  typedef enum logic {OWN_FETCH, OWN_DATA} owner_e;

  state_e            state_q, state_d;
  owner_e            owner_q, owner_d;
  owner_e            last_owner_q, last_owner_d;
  logic              we_q, we_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              if_ack_q, if_ack_d;
  logic              d_ack_q, d_ack_d;
  logic              mem_we_q, mem_we_d;
  logic              busy_q, busy_d;
  logic [ADDR_W-1:0] mar_addr_q, mar_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              grant_fetch;

  // Fetch wins when alone, or when both request and data owned the previous slot.
  assign grant_fetch = if_req && (!d_req || (last_owner_q == OWN_DATA));

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    we_d         = we_q;
    cnt_d        = cnt_q;
    if_ack_d     = 1'b0;
    d_ack_d      = 1'b0;
    mem_we_d     = 1'b0;
    mar_addr_d   = mar_addr_q;
    mem_wdata_d  = mem_wdata_q;
    rdata_d      = rdata_q;

    unique case (state_q)
      IDLE: begin
        if (if_req || d_req) begin
          owner_d      = grant_fetch ? OWN_FETCH : OWN_DATA;
          last_owner_d = owner_d;
          we_d         = grant_fetch ? 1'b0 : d_we;
          mar_addr_d   = grant_fetch ? if_addr : d_addr;
          mem_wdata_d  = d_wdata;
          cnt_d        = CNT_W'(MEM_LAT);
          state_d      = WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        // Strobe lands in the cycle after the MAR has registered the address.
        if (we_q && (cnt_q == CNT_W'(MEM_LAT))) mem_we_d = 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          if (!we_q) rdata_d = mem_rdata;
          if_ack_d = (owner_q == OWN_FETCH);
          d_ack_d  = (owner_q == OWN_DATA);
          state_d  = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      owner_q      <= OWN_DATA;
      last_owner_q <= OWN_DATA;
      we_q         <= 1'b0;
      cnt_q        <= '0;
      if_ack_q     <= 1'b0;
      d_ack_q      <= 1'b0;
      mem_we_q     <= 1'b0;
      busy_q       <= 1'b0;
      mar_addr_q   <= '0;
      mem_wdata_q  <= '0;
      rdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      we_q         <= we_d;
      cnt_q        <= cnt_d;
      if_ack_q     <= if_ack_d;
      d_ack_q      <= d_ack_d;
      mem_we_q     <= mem_we_d;
      busy_q       <= busy_d;
      mar_addr_q   <= mar_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      rdata_q      <= rdata_d;
    end
  end

  assign if_ack    = if_ack_q;
  assign d_ack     = d_ack_q;
  assign mem_we    = mem_we_q;
  assign busy      = busy_q;
  assign mar_addr  = mar_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign rdata     = rdata_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: a MEM_LAT=3 instance plus a MEM_LAT=5 instance.
module tb_mem_access_ctrl;

  localparam int unsigned ADDR_W = 11;
  localparam int unsigned DATA_W = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic              if_req, d_req, d_we;
  logic [ADDR_W-1:0] if_addr, d_addr;
  logic [DATA_W-1:0] d_wdata, mem_rdata;
  logic              if_ack, d_ack, mem_we, busy;
  logic [DATA_W-1:0] rdata, mem_wdata;
  logic [ADDR_W-1:0] mar_addr;

  logic              if_req5, d_req5, d_we5;
  logic [ADDR_W-1:0] if_addr5, d_addr5;
  logic [DATA_W-1:0] d_wdata5, mem_rdata5;
  logic              if_ack5, d_ack5, mem_we5, busy5;
  logic [DATA_W-1:0] rdata5, mem_wdata5;
  logic [ADDR_W-1:0] mar_addr5;

  int n_vec = 0;
  int n_err = 0;

  mem_access_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LAT(3)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_ack(d_ack),
    .rdata(rdata), .mar_addr(mar_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  mem_access_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LAT(5)) dut5 (
    .clk(clk), .rst(rst),
    .if_req(if_req5), .if_addr(if_addr5), .if_ack(if_ack5),
    .d_req(d_req5), .d_we(d_we5), .d_addr(d_addr5), .d_wdata(d_wdata5), .d_ack(d_ack5),
    .rdata(rdata5), .mar_addr(mar_addr5), .mem_we(mem_we5), .mem_wdata(mem_wdata5),
    .mem_rdata(mem_rdata5), .busy(busy5)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    if_req = 0; if_addr = '0; d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0; mem_rdata = '0;
    if_req5 = 0; if_addr5 = '0; d_req5 = 0; d_we5 = 0; d_addr5 = '0; d_wdata5 = '0;
    mem_rdata5 = '0;

    // Reset state
    step();
    step();
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_mar", 64'(mar_addr), 64'd0);
    chk("rst_rdata", 64'(rdata), 64'd0);
    chk("rst_acks", 64'({if_ack, d_ack, mem_we}), 64'd0);
    chk("rst_wdata", 64'(mem_wdata), 64'd0);
    rst = 1'b0;
    step();
    chk("idle_busy", 64'(busy), 64'd0);

    // Single fetch read
    if_addr = 11'h005; if_req = 1; mem_rdata = 32'hDEADBEEF;
    step();
    chk("f_mar", 64'(mar_addr), 64'h005);
    chk("f_busy", 64'(busy), 64'd1);
    step();
    chk("f_c2_we", 64'(mem_we), 64'd0);
    step();
    chk("f_c3_ack", 64'({if_ack, d_ack}), 64'd0);
    step();
    chk("f_ack", 64'({if_ack, d_ack}), 64'b10);
    chk("f_rdata", 64'(rdata), 64'hDEADBEEF);
    if_req = 0;
    step();
    chk("f_done", 64'({if_ack, d_ack, busy}), 64'd0);

    // Data write
    d_req = 1; d_we = 1; d_addr = 11'h7FF; d_wdata = 32'h12345678; mem_rdata = 32'hCAFEF00D;
    step();
    chk("w_mar", 64'(mar_addr), 64'h7FF);
    chk("w_wdata", 64'(mem_wdata), 64'h12345678);
    chk("w_c1_we", 64'(mem_we), 64'd0);
    step();
    chk("w_c2_we", 64'(mem_we), 64'd1);
    step();
    chk("w_c3_we", 64'(mem_we), 64'd0);
    step();
    chk("w_ack", 64'({if_ack, d_ack}), 64'b01);
    chk("w_rdata_hold", 64'(rdata), 64'hDEADBEEF);
    d_req = 0; d_we = 0;
    step();
    chk("w_done", 64'({d_ack, busy}), 64'd0);

    // Simultaneous requests after reset: fetch, data, fetch
    do_reset();
    if_req = 1; d_req = 1; if_addr = 11'h010; d_addr = 11'h020; mem_rdata = 32'h11111111;
    step();
    chk("rr1_mar", 64'(mar_addr), 64'h010);
    step(); step(); step();
    chk("rr1_ack", 64'({if_ack, d_ack}), 64'b10);
    step();
    chk("rr1_gap", 64'({if_ack, d_ack, busy}), 64'd0);
    step();
    chk("rr2_mar", 64'(mar_addr), 64'h020);
    step(); step();
    chk("rr2_c3", 64'({if_ack, d_ack}), 64'b00);
    step();
    chk("rr2_ack", 64'({if_ack, d_ack}), 64'b01);
    chk("rr2_rdata", 64'(rdata), 64'h11111111);
    step(); step();
    chk("rr3_mar", 64'(mar_addr), 64'h010);
    step(); step(); step();
    chk("rr3_ack", 64'({if_ack, d_ack}), 64'b10);
    if_req = 0; d_req = 0;
    step();

    // Data request arriving during a fetch
    if_req = 1; if_addr = 11'h0AA; mem_rdata = 32'h22222222;
    step();
    chk("bz_mar", 64'(mar_addr), 64'h0AA);
    d_req = 1; d_we = 0; d_addr = 11'h0BB; if_addr = 11'h0CC;
    step();
    chk("bz_mar_hold", 64'(mar_addr), 64'h0AA);
    step(); step();
    chk("bz_f_ack", 64'({if_ack, d_ack}), 64'b10);
    if_req = 0;
    step();
    step();
    chk("bz_d_mar", 64'(mar_addr), 64'h0BB);
    step(); step(); step();
    chk("bz_d_ack", 64'({if_ack, d_ack}), 64'b01);
    d_req = 0;
    step();

    // Reset mid-WAIT on a write, request held across reset
    d_req = 1; d_we = 1; d_addr = 11'h155; d_wdata = 32'hA5A5A5A5;
    step();
    step();
    chk("rw_we_pre", 64'(mem_we), 64'd1);
    #1 rst = 1'b1;
    #1;
    chk("rw_async", 64'({mem_we, d_ack, if_ack, busy}), 64'd0);
    chk("rw_mar", 64'(mar_addr), 64'd0);
    @(posedge clk); #1 rst = 1'b0;
    chk("rw_noack", 64'({d_ack, busy}), 64'd0);
    step();
    chk("rw_restart", 64'(mar_addr), 64'h155);
    step();
    chk("rw_we2", 64'(mem_we), 64'd1);
    step(); step();
    chk("rw_ack", 64'({if_ack, d_ack}), 64'b01);
    d_req = 0; d_we = 0;
    step();

    // MEM_LAT=5 instance
    if_req5 = 1; if_addr5 = 11'h033; mem_rdata5 = 32'h55AA55AA;
    step();
    chk("l5_mar", 64'(mar_addr5), 64'h033);
    step(); step(); step(); step();
    chk("l5_c5", 64'(if_ack5), 64'd0);
    step();
    chk("l5_ack", 64'({if_ack5, d_ack5}), 64'b10);
    chk("l5_rdata", 64'(rdata5), 64'h55AA55AA);
    if_req5 = 0;
    step();
    d_req5 = 1; d_we5 = 1; d_addr5 = 11'h044; d_wdata5 = 32'h0BADCAFE;
    step();
    chk("l5w_c1", 64'(mem_we5), 64'd0);
    step();
    chk("l5w_c2", 64'(mem_we5), 64'd1);
    chk("l5w_wdata", 64'(mem_wdata5), 64'h0BADCAFE);
    step();
    chk("l5w_c3", 64'(mem_we5), 64'd0);
    step(); step();
    chk("l5w_c5", 64'(d_ack5), 64'd0);
    step();
    chk("l5w_ack", 64'({if_ack5, d_ack5}), 64'b01);
    chk("l5w_rdata", 64'(rdata5), 64'h55AA55AA);
    d_req5 = 0; d_we5 = 0;
    step();
    chk("l5_done", 64'({d_ack5, busy5}), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
